data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 109 ++++++++++
 tb/tb_data_mem_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU load/store handshake: word-addressed RAM,
// programmable wait states, one-cycle ready pulse. `DMEM_ACCESS_CNT_EN adds access counters.
module data_mem_responder #(
  parameter int AW  = 10,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic          st_en,
  input  logic [31:0]   addr,
  input  logic [DW-1:0] write_data,
  output logic [DW-1:0] read_data,
  output logic          ready,
  output logic          err
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [15:0]   ld_count,
  output logic [15:0]   st_count
`endif
);

  localparam int DEPTH = 2**AW;
  localparam logic [3:0] LAT_C = 4'(LAT);

  typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          take, done;
  logic [AW-1:0] idx_p0;
  logic [DW-1:0] wdata_p0;
  logic          is_st_p0, oor_p0, conflict_p0;
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (ld_en || st_en) begin
                 take      = 1'b1;
                 state_nxt = WAIT;
               end
      WAIT:    if (cnt == 4'd0) begin
                 done      = 1'b1;
                 state_nxt = RELEASE;
               end
      RELEASE: if (!ld_en && !st_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture: inputs are sampled once, then ignored until the next IDLE
  always_ff @(posedge clk) begin
    if (take) begin
      idx_p0      <= addr[AW-1:0];
      wdata_p0    <= write_data;
      is_st_p0    <= st_en;
      oor_p0      <= |addr[31:AW];
      conflict_p0 <= ld_en & st_en;
    end
  end

  // Completion: wait countdown, ready pulse, load result and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 4'd0;
      ready     <= 1'b0;
      err       <= 1'b0;
      read_data <= '0;
    end else begin
      ready <= done;
      if (take)
        cnt <= LAT_C;
      else if (state == WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (done && (oor_p0 || conflict_p0))
        err <= 1'b1;
      if (done && !is_st_p0)
        read_data <= oor_p0 ? '0 : mem[idx_p0];
    end
  end

  // RAM is never reset; done is low while rst holds state in IDLE
  always_ff @(posedge clk) begin
    if (done && is_st_p0 && !oor_p0)
      mem[idx_p0] <= wdata_p0;
  end

`ifdef DMEM_ACCESS_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_count <= 16'd0;
      st_count <= 16'd0;
    end else if (done) begin
      if (is_st_p0) st_count <= st_count + 16'd1;
      else          ld_count <= ld_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LAT=2 and LAT=0 instances, scoreboard of expected results.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en [2];
  logic        st_en [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] read_data [2];
  logic        ready [2];
  logic        err   [2];
`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] ld_count [2];
  logic [15:0] st_count [2];
  int          ldc_m [2];
  int          stc_m [2];
`endif

  typedef struct { logic [31:0] rd; logic er; } exp_t;
  exp_t        sb [$];
  logic [31:0] mm [int];
  logic [31:0] rd_m  [2];
  logic        err_m [2];
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.AW(10), .DW(32), .LAT(2)) dut_l2 (
    .clk(clk), .rst(rst), .ld_en(ld_en[0]), .st_en(st_en[0]), .addr(addr[0]),
    .write_data(wdata[0]), .read_data(read_data[0]), .ready(ready[0]), .err(err[0])
`ifdef DMEM_ACCESS_CNT_EN
    , .ld_count(ld_count[0]), .st_count(st_count[0])
`endif
  );

  data_mem_responder #(.AW(10), .DW(32), .LAT(0)) dut_l0 (
    .clk(clk), .rst(rst), .ld_en(ld_en[1]), .st_en(st_en[1]), .addr(addr[1]),
    .write_data(wdata[1]), .read_data(read_data[1]), .ready(ready[1]), .err(err[1])
`ifdef DMEM_ACCESS_CNT_EN
    , .ld_count(ld_count[1]), .st_count(st_count[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rd_m[i]  = '0;
      err_m[i] = 1'b0;
`ifdef DMEM_ACCESS_CNT_EN
      ldc_m[i] = 0;
      stc_m[i] = 0;
`endif
    end
  endtask

  // One request: drive, predict, wait bounded for ready, compare, hold, release.
  task automatic req(input int s, input bit st, input bit ld, input logic [31:0] a,
                     input logic [31:0] wd, input int hold, input string tag);
    exp_t e;
    int   cyc, extra, lat;
    bit   oor;
    lat = (s == 0) ? 2 : 0;
    oor = (a[31:10] != 22'd0);
    if (oor || (st && ld)) err_m[s] = 1'b1;
    if (st) begin
      if (!oor) mm[s*4096 + int'(a[9:0])] = wd;
    end else begin
      rd_m[s] = oor ? 32'd0 : mm[s*4096 + int'(a[9:0])];
    end
`ifdef DMEM_ACCESS_CNT_EN
    if (st) stc_m[s]++; else ldc_m[s]++;
`endif
    @(negedge clk);
    ld_en[s] = ld; st_en[s] = st; addr[s] = a; wdata[s] = wd;
    e.rd = rd_m[s]; e.er = err_m[s];
    sb.push_back(e);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!ready[s] && cyc < 40);
    chk({tag, "_latency"}, 32'(cyc), 32'(lat + 2));
    e = sb.pop_front();
    chk({tag, "_read_data"}, read_data[s], e.rd);
    chk({tag, "_err"}, {31'd0, err[s]}, {31'd0, e.er});
    extra = 0;
    repeat (hold + 1) begin
      @(posedge clk); #1;
      if (ready[s]) extra++;
    end
    chk({tag, "_single_pulse"}, 32'(extra), 32'd0);
    @(negedge clk);
    ld_en[s] = 1'b0; st_en[s] = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ld_en[i] = 1'b0; st_en[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_read_data", read_data[i], 32'd0);
      chk("rst_ready", {31'd0, ready[i]}, 32'd0);
      chk("rst_err", {31'd0, err[i]}, 32'd0);
`ifdef DMEM_ACCESS_CNT_EN
      chk("rst_ld_count", {16'd0, ld_count[i]}, 32'd0);
      chk("rst_st_count", {16'd0, st_count[i]}, 32'd0);
`endif
    end
    @(negedge clk);
    rst = 1'b0;

    req(0, 1, 0, 32'd5, 32'hDEADBEEF, 0, "store5");
    req(0, 0, 1, 32'd5, 32'h0, 0, "load5");
    req(0, 1, 0, 32'd3, 32'h33333333, 0, "store3");
    req(0, 1, 0, 32'd0, 32'h0BADF00D, 0, "store0");
    req(0, 0, 1, 32'd5, 32'h0, 10, "held_load5");
    req(0, 0, 1, 32'd3, 32'h0, 0, "reissue_load3");
    req(0, 0, 1, 32'h400, 32'h0, 0, "oor_load");
    req(0, 0, 1, 32'd0, 32'h0, 0, "load0_after_oor");
    req(0, 1, 1, 32'd7, 32'h1234, 0, "conflict7");
    req(0, 0, 1, 32'd7, 32'h0, 0, "load7");

    // Reset while a store sits in WAIT: the store must never land.
    @(negedge clk);
    st_en[0] = 1'b1; addr[0] = 32'd3; wdata[0] = 32'hAAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, ready[0]}, 32'd0);
    chk("midrst_err", {31'd0, err[0]}, 32'd0);
    chk("midrst_read_data", read_data[0], 32'd0);
    model_reset();
    @(negedge clk);
    st_en[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready[0]) pulses++;
    end
    chk("midrst_no_pulse", 32'(pulses), 32'd0);
    req(0, 0, 1, 32'd3, 32'h0, 0, "load3_after_rst");

    req(1, 1, 0, 32'd1, 32'h11112222, 0, "l0_store1");
    req(1, 1, 0, 32'd2, 32'h33334444, 0, "l0_store2");
    req(1, 1, 0, 32'h1000, 32'h55556666, 0, "l0_oor_store");
    req(1, 0, 1, 32'd1, 32'h0, 0, "l0_load1");
    req(1, 0, 1, 32'd2, 32'h0, 0, "l0_load2");
`ifdef DMEM_ACCESS_CNT_EN
    for (int i = 0; i < 2; i++) begin
      chk("ld_count", {16'd0, ld_count[i]}, 32'(ldc_m[i]));
      chk("st_count", {16'd0, st_count[i]}, 32'(stc_m[i]));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
